vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  Display-side consumer of the tile/framebuffer memory's pixel port. Generates
//  640x480@60 VGA raster timing from clk, drives pixel_x/pixel_y into the memory,
//  samples the returned 12-bit pixel once the memory's fixed 2-clk display
//  latency has elapsed, and drives registered RGB444 plus sync to the DAC pins.
//  Also exports a vblank level and a one-clk frame_start pulse for CPU-visible
//  frame sync.
// PARAMETERS
//  CLK_DIV      4    clk cycles per pixel; must be >= 3 (memory latency 2 + 1 sample)
//  H_VISIBLE    640  active pixels per line
//  H_FRONT      16   horizontal front porch, pixels
//  H_SYNC       96   hsync width, pixels
//  H_BACK       48   horizontal back porch, pixels
//  V_VISIBLE    480  active lines per frame
//  V_FRONT      10   vertical front porch, lines
//  V_SYNC       2    vsync width, lines
//  V_BACK       33   vertical back porch, lines
// PORTS
//  clk          in   1   system clock, shared with memory
//  rst_n        in   1   asynchronous active-low reset
//  pixel        in   12  {R[11:8],G[7:4],B[3:0]} returned by memory for pixel_x/pixel_y
//  pixel_x      out  10  column requested from memory
//  pixel_y      out  10  row requested from memory
//  vga_r        out  4   red to DAC
//  vga_g        out  4   green to DAC
//  vga_b        out  4   blue to DAC
//  vga_hs       out  1   horizontal sync, active low
//  vga_vs       out  1   vertical sync, active low
//  vblank       out  1   high while v_cnt >= V_VISIBLE
//  frame_start  out  1   one-clk pulse on the clk where v_cnt wraps to 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): div_cnt=h_cnt=v_cnt=0; pixel_x=pixel_y=0; vga_r/g/b=0;
//    vga_hs=vga_vs=1; vblank=0; frame_start=0. Cleared immediately mid-frame; raster
//    restarts at (0,0) after release, with no partial-line recovery.
//  - div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt==CLK_DIV-1).
//  - On pix_en: h_cnt advances 0..H_TOTAL-1 (H_TOTAL=800) and wraps. On h wrap,
//    v_cnt advances 0..V_TOTAL-1 (525) and wraps. Counters are 10 bits.
//  - Combinational visible = (h_cnt<H_VISIBLE)&&(v_cnt<V_VISIBLE).
//  - pixel_x = (h_cnt<H_VISIBLE)? h_cnt : 0; pixel_y = (v_cnt<V_VISIBLE)? v_cnt : 0.
//    These are registered off the counters and change only on the clk after pix_en.
//    They stay in 0..639 / 0..479 so memory never addresses past the framebuffer.
//  - Sampling: on the pix_en clk, pixel reflects the current pixel_x/pixel_y. They
//    have been stable for CLK_DIV>=3 clks, and memory latency is 2.
//    vga_{r,g,b} <= visible ? pixel fields : 0
//    vga_hs <= ~(h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC))
//    vga_vs <= ~(v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC))
//    RGB and sync are updated on the same edge, so they stay aligned, lagging the
//    counter by one pixel period.
//  - vblank is registered and updates on pix_en from v_cnt.
//  - frame_start=1 for exactly one clk: the clk after the pix_en on which h and v
//    both wrap (transition 524/799 -> 0/0). Otherwise 0.
//  - Outputs hold constant between pix_en edges; no combinational path from pixel to
//    any output.
// TESTING
//  1 Reset release, CLK_DIV=4: first pix_en at clk 3. h_cnt=1 after clk 4.
//    vga_hs/vga_vs=1 and RGB=0 held throughout reset.
//  2 Line timing: vga_hs falls at h_cnt 656 and rises at 752. Low width = 96*4 = 384 clk.
//    Line period = 3200 clk.
//  3 Frame timing: vga_vs low for lines 490-491. Frame = 525*3200 = 1,680,000 clk.
//    frame_start pulses once per frame, width 1 clk. vblank is high for lines 480-524.
//  4 Pixel path, 2-clk-latency memory model returning {x[3:0],y[3:0],4'hA}: at screen
//    (5,3), vga_r=5, g=3, b=A on the pix_en after the counter reaches (5,3).
//    RGB=0 whenever h>=640 or v>=480.
//  5 Address clamp: sweep a whole frame. pixel_x never exceeds 639 and pixel_y never
//    exceeds 479. Both read 0 during blanking.
//  6 Mid-frame reset at (h=300,v=200): all outputs reach reset values asynchronously.
//    After release, the raster restarts at (0,0) and frame_start fires 1,680,000 clk later.

Source files
------------

// File: rtl/vga_scanout.sv
// VGA raster generator and scanout stage: drives pixel_x/pixel_y to a 2-clk-latency
// framebuffer, samples the returned RGB444 on pix_en and registers RGB/sync/vblank.
module vga_scanout #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pixel,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank,
    output logic        frame_start
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SE  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_MAX = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
    localparam logic [9:0] V_SS  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SE  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_MAX = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic [9:0]    px_q, px_d, py_q, py_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          hs_q, hs_d, vs_q, vs_d, vb_q, vb_d, fs_q, fs_d;
    logic          pix_en, h_wrap, v_wrap, visible;

    always_comb begin
        pix_en  = (div_q == DIV_MAX);
        h_wrap  = (h_q == H_MAX);
        v_wrap  = (v_q == V_MAX);
        visible = (h_q < H_VIS) && (v_q < V_VIS);

        div_d = pix_en ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        px_d  = px_q;
        py_d  = py_q;
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        vb_d  = vb_q;
        fs_d  = 1'b0;

        if (pix_en) begin
            h_d = h_wrap ? '0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 10'd1;
            end
            // Addresses follow the new counter value so memory has a full pixel period to answer.
            px_d  = (h_d < H_VIS) ? h_d : '0;
            py_d  = (v_d < V_VIS) ? v_d : '0;
            rgb_d = visible ? pixel : '0;
            hs_d  = ~((h_q >= H_SS) && (h_q < H_SE));
            vs_d  = ~((v_q >= V_SS) && (v_q < V_SE));
            vb_d  = (v_q >= V_VIS);
            fs_d  = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            px_q  <= '0;
            py_q  <= '0;
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            vb_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            px_q  <= px_d;
            py_q  <= py_d;
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vb_q  <= vb_d;
            fs_q  <= fs_d;
        end
    end

    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vblank      = vb_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced raster; a reference raster model pushes expected
// outputs on each pix_en and the sweep pops them against the registered DUT outputs.
module tb_vga_scanout;

    localparam int CD = 4;
    localparam int HV = 16, HF = 2, HS = 3, HB = 2;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT * CD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] pixel = '0;
    logic [11:0] mem_p1 = '0;
    logic [9:0]  pixel_x, pixel_y;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vblank, frame_start;

    always #5 clk = ~clk;

    vga_scanout #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel(pixel),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vblank(vblank), .frame_start(frame_start)
    );

    // Framebuffer with 2-clk read latency returning {x[3:0], y[3:0], A}.
    always @(posedge clk) begin
        mem_p1 <= {pixel_x[3:0], pixel_y[3:0], 4'hA};
        pixel  <= mem_p1;
    end

    typedef struct {
        logic [3:0] r, g, b;
        logic       hs, vs, vb, fs;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t rst_exp = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b1, vs: 1'b1, vb: 1'b0, fs: 1'b0};
    int   m_div = 0, m_h = 0, m_v = 0, m_px = 0, m_py = 0;
    int   checks = 0, fails = 0;
    int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_t[$], vb_t[$];
    logic [9:0] px_trace[$];

    function automatic int h_next(int h);
        return (h == HT - 1) ? 0 : h + 1;
    endfunction

    function automatic int v_next(int h, int v);
        if (h != HT - 1) return v;
        return (v == VT - 1) ? 0 : v + 1;
    endfunction

    function automatic exp_t expect_at(int h, int v);
        exp_t e;
        bit vis = (h < HV) && (v < VV);
        e.r  = vis ? 4'(h) : 4'h0;
        e.g  = vis ? 4'(v) : 4'h0;
        e.b  = vis ? 4'hA : 4'h0;
        e.hs = !((h >= HV + HF) && (h < HV + HF + HS));
        e.vs = !((v >= VV + VF) && (v < VV + VF + VS));
        e.vb = (v >= VV);
        e.fs = (h == HT - 1) && (v == VT - 1);
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div <= 0; m_h <= 0; m_v <= 0; m_px <= 0; m_py <= 0;
        end else if (m_div == CD - 1) begin
            q.push_back(expect_at(m_h, m_v));
            m_div <= 0;
            m_h   <= h_next(m_h);
            m_v   <= v_next(m_h, m_v);
            m_px  <= (h_next(m_h) < HV) ? h_next(m_h) : 0;
            m_py  <= (v_next(m_h, m_v) < VV) ? v_next(m_h, m_v) : 0;
        end else begin
            m_div <= m_div + 1;
        end
    end

    task automatic sweep(input int n);
        logic hs_p, vs_p, fs_exp;
        hs_fall.delete(); hs_rise.delete(); vs_fall.delete(); vs_rise.delete();
        fs_t.delete(); vb_t.delete(); px_trace.delete();
        hs_p = vga_hs;
        vs_p = vga_vs;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (q.size() > 0) begin
                cur = q.pop_front();
                fs_exp = cur.fs;
            end else begin
                fs_exp = 1'b0;
            end
            checks++;
            if ({vga_r, vga_g, vga_b} !== {cur.r, cur.g, cur.b}) begin
                fails++;
                $display("FAIL rgb cyc=%0d got=%h exp=%h", c, {vga_r, vga_g, vga_b}, {cur.r, cur.g, cur.b});
            end
            checks++;
            if ({vga_hs, vga_vs} !== {cur.hs, cur.vs}) begin
                fails++;
                $display("FAIL sync cyc=%0d got hs/vs=%b%b exp=%b%b", c, vga_hs, vga_vs, cur.hs, cur.vs);
            end
            checks++;
            if (vblank !== cur.vb) begin
                fails++;
                $display("FAIL vblank cyc=%0d got=%b exp=%b", c, vblank, cur.vb);
            end
            checks++;
            if (frame_start !== fs_exp) begin
                fails++;
                $display("FAIL frame_start cyc=%0d got=%b exp=%b", c, frame_start, fs_exp);
            end
            checks++;
            if ({22'd0, pixel_x} !== m_px || {22'd0, pixel_y} !== m_py) begin
                fails++;
                $display("FAIL addr cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", c, pixel_x, pixel_y, m_px, m_py);
            end
            checks++;
            if (pixel_x > 10'(HV - 1) || pixel_y > 10'(VV - 1)) begin
                fails++;
                $display("FAIL addr_clamp cyc=%0d got=(%0d,%0d) limit=(%0d,%0d)", c, pixel_x, pixel_y, HV - 1, VV - 1);
            end
            px_trace.push_back(pixel_x);
            if (hs_p && !vga_hs) hs_fall.push_back(c);
            if (!hs_p && vga_hs) hs_rise.push_back(c);
            if (vs_p && !vga_vs) vs_fall.push_back(c);
            if (!vs_p && vga_vs) vs_rise.push_back(c);
            if (frame_start) fs_t.push_back(c);
            if (vblank) vb_t.push_back(c);
            hs_p = vga_hs;
            vs_p = vga_vs;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vblank, frame_start, pixel_x, pixel_y} !==
                {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
                fails++;
                $display("FAIL reset_hold got rgb=%h hs=%b vs=%b vb=%b fs=%b px=%0d py=%0d exp rgb=000 hs=1 vs=1 vb=0 fs=0 px=0 py=0",
                         {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vblank, frame_start, pixel_x, pixel_y);
            end
        end
        q.delete();
        cur = rst_exp;
        rst_n = 1'b1;
        sweep(4);
        checks++;
        if (px_trace[2] !== 10'd0) begin
            fails++;
            $display("FAIL first_pix_en_early got pixel_x=%0d after clk 2 exp=0", px_trace[2]);
        end
        checks++;
        if (px_trace[3] !== 10'd1) begin
            fails++;
            $display("FAIL first_pix_en got pixel_x=%0d after clk 3 exp=1", px_trace[3]);
        end
    endtask

    task automatic test_pixel_path();
        sweep(2 * FRAME + 50);
    endtask

    task automatic test_line_timing();
        checks++;
        if (hs_fall.size() < 2 || hs_rise.size() < 1) begin
            fails++;
            $display("FAIL hs_edges got falls=%0d rises=%0d exp >=2 and >=1", hs_fall.size(), hs_rise.size());
        end else begin
            checks++;
            if (hs_fall[0] != (HV + HF + 1) * CD - 4) begin
                fails++;
                $display("FAIL hs_fall_pos got=%0d exp=%0d", hs_fall[0], (HV + HF + 1) * CD - 4);
            end
            checks++;
            if (hs_rise[0] - hs_fall[0] != HS * CD) begin
                fails++;
                $display("FAIL hs_width got=%0d exp=%0d", hs_rise[0] - hs_fall[0], HS * CD);
            end
            checks++;
            if (hs_fall[1] - hs_fall[0] != HT * CD) begin
                fails++;
                $display("FAIL line_period got=%0d exp=%0d", hs_fall[1] - hs_fall[0], HT * CD);
            end
        end
    endtask

    task automatic test_frame_timing();
        int vb_cnt;
        checks++;
        if (vs_fall.size() < 1 || vs_rise.size() < 1 || vs_rise[0] - vs_fall[0] != VS * HT * CD) begin
            fails++;
            $display("FAIL vs_width got falls=%0d rises=%0d width=%0d exp=%0d", vs_fall.size(), vs_rise.size(),
                     (vs_fall.size() > 0 && vs_rise.size() > 0) ? vs_rise[0] - vs_fall[0] : -1, VS * HT * CD);
        end
        checks++;
        if (fs_t.size() != 2) begin
            fails++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_t.size());
        end else begin
            checks++;
            if (fs_t[0] != FRAME - 4 || fs_t[1] - fs_t[0] != FRAME) begin
                fails++;
                $display("FAIL frame_period got first=%0d period=%0d exp first=%0d period=%0d",
                         fs_t[0], fs_t[1] - fs_t[0], FRAME - 4, FRAME);
            end
            vb_cnt = 0;
            foreach (vb_t[i]) if (vb_t[i] >= fs_t[0] && vb_t[i] < fs_t[1]) vb_cnt++;
            checks++;
            if (vb_cnt != (VT - VV) * HT * CD) begin
                fails++;
                $display("FAIL vblank_len got=%0d exp=%0d", vb_cnt, (VT - VV) * HT * CD);
            end
        end
    endtask

    task automatic test_midframe_reset();
        int waited = 0;
        while (!(m_h == 10 && m_v == 5) && waited < 2 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 2 * FRAME || pixel_x !== 10'd10 || pixel_y !== 10'd5) begin
            fails++;
            $display("FAIL midframe_reach got waited=%0d px=%0d py=%0d exp px=10 py=5", waited, pixel_x, pixel_y);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vblank, frame_start, pixel_x, pixel_y} !==
            {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
            fails++;
            $display("FAIL async_reset got rgb=%h hs=%b vs=%b vb=%b fs=%b px=%0d py=%0d exp rgb=000 hs=1 vs=1 vb=0 fs=0 px=0 py=0",
                     {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vblank, frame_start, pixel_x, pixel_y);
        end
        repeat (3) @(negedge clk);
        q.delete();
        cur = rst_exp;
        rst_n = 1'b1;
        sweep(FRAME + 20);
        checks++;
        if (fs_t.size() < 1 || fs_t[0] != FRAME) begin
            fails++;
            $display("FAIL restart_frame_start got count=%0d first=%0d exp first=%0d",
                     fs_t.size(), (fs_t.size() > 0) ? fs_t[0] : -1, FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_pixel_path();
        test_line_timing();
        test_frame_timing();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
